// File: rtl/sine_wave_analyzer.sv
// Sine wave analyzer: locks onto rising midpoint crossings of an offset-binary stream and
// reports period, peak max/min and amplitude per cycle. Optional hysteresis: SINE_ANA_HYST_EN.
module sine_wave_analyzer #(
  parameter int DW    = 8,
  parameter int MID   = 128,
  parameter int CNT_W = 16,
  parameter int HYST  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DW-1:0]    din,
  input  logic             din_valid,
  output logic [CNT_W-1:0] period,
  output logic [DW-1:0]    pk_max,
  output logic [DW-1:0]    pk_min,
  output logic [DW-1:0]    amp,
  output logic             meas_valid,
  output logic             locked,
  output logic             timeout
);

  typedef enum logic {SEARCH, TRACK} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [DW-1:0]    run_max, run_min;
  logic             above, cur_above, crossing, cnt_full;

`ifdef SINE_ANA_HYST_EN
  localparam int BAND = HYST;
`else
  // A zero-width band makes the threshold logic reduce to a plain din >= MID compare.
  localparam int BAND = HYST * 0;
`endif

  localparam logic [DW:0] HI_TH = (DW+1)'(MID + BAND);
  localparam logic [DW:0] LO_TH = (DW+1)'(MID - BAND);

  always_comb begin
    cur_above = above;
    if ({1'b0, din} >= HI_TH)
      cur_above = 1'b1;
    else if ({1'b0, din} < LO_TH)
      cur_above = 1'b0;
  end

  assign crossing = din_valid && !above && cur_above;
  assign cnt_full = (cnt == '1);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= SEARCH;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (din_valid) begin
      case (state)
        SEARCH: if (crossing) state_nx = TRACK;
        TRACK:  if (!crossing && cnt_full) state_nx = SEARCH;
        default: state_nx = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= '0;
      run_max    <= '0;
      run_min    <= '1;
      above      <= 1'b1;
      period     <= '0;
      pk_max     <= '0;
      pk_min     <= '0;
      amp        <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
      if (din_valid) begin
        above <= cur_above;
        if (state == SEARCH) begin
          if (crossing) begin
            cnt     <= CNT_W'(1);
            run_max <= din;
            run_min <= din;
          end
        end else if (crossing) begin
          // Closing crossing sample also opens the next cycle, so a crossing beats timeout.
          period     <= cnt;
          pk_max     <= run_max;
          pk_min     <= run_min;
          amp        <= run_max - run_min;
          meas_valid <= 1'b1;
          locked     <= 1'b1;
          cnt        <= CNT_W'(1);
          run_max    <= din;
          run_min    <= din;
        end else if (cnt_full) begin
          timeout <= 1'b1;
          locked  <= 1'b0;
        end else begin
          cnt <= cnt + CNT_W'(1);
          if (din > run_max) run_max <= din;
          if (din < run_min) run_min <= din;
        end
      end
    end
  end

endmodule

// File: tb/tb_sine_wave_analyzer.sv
// Directed self-checking bench for sine_wave_analyzer (default CNT_W and a CNT_W=8 instance).
module tb_sine_wave_analyzer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  din = '0;
  logic        din_valid = 1'b0;

  logic [15:0] period;
  logic [7:0]  pk_max, pk_min, amp;
  logic        meas_valid, locked, timeout;

  logic [7:0]  period8;
  logic [7:0]  pk_max8, pk_min8, amp8;
  logic        meas_valid8, locked8, timeout8;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mv_n = 0, mv_last = 0, mv_gap = 0, to_n = 0;
  int mv8_n = 0, to8_n = 0;

  always #5 clk = ~clk;

  sine_wave_analyzer dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .period(period), .pk_max(pk_max), .pk_min(pk_min), .amp(amp),
    .meas_valid(meas_valid), .locked(locked), .timeout(timeout)
  );

  sine_wave_analyzer #(.CNT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .period(period8), .pk_max(pk_max8), .pk_min(pk_min8), .amp(amp8),
    .meas_valid(meas_valid8), .locked(locked8), .timeout(timeout8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic [7:0] d, input logic v);
    @(negedge clk);
    din = d;
    din_valid = v;
    @(posedge clk);
    #1;
    cyc++;
    if (meas_valid) begin
      mv_n++;
      mv_gap = cyc - mv_last;
      mv_last = cyc;
    end
    if (timeout) to_n++;
    if (meas_valid8) mv8_n++;
    if (timeout8) to8_n++;
  endtask

  task automatic block(input logic [7:0] d, input int n, input logic toggle);
    for (int i = 0; i < n; i++) begin
      step(d, 1'b1);
      if (toggle) step(8'd0, 1'b0);
    end
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    step(8'd200, 1'b1);
    check({tag, "_period"}, period, 0);
    check({tag, "_pkmax"}, pk_max, 0);
    check({tag, "_pkmin"}, pk_min, 0);
    check({tag, "_amp"}, amp, 0);
    check({tag, "_flags"}, {meas_valid, locked, timeout}, 0);
    check({tag, "_flags8"}, {meas_valid8, locked8, timeout8}, 0);
    rst_n = 1'b1;
    mv_n = 0; mv_last = cyc; mv_gap = 0; to_n = 0; mv8_n = 0; to8_n = 0;
  endtask

  // Leaves dut8 in TRACK with a 32/200/50/150 measurement, just past the opening crossing.
  task automatic lock8();
    block(8'd50, 16, 1'b0);
    block(8'd200, 16, 1'b0);
    block(8'd50, 16, 1'b0);
    step(8'd200, 1'b1);
    check("lock8_mv", meas_valid8, 1);
    check("lock8_period", period8, 32);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Continuous square wave
    do_reset("rst1");
    block(8'd50, 16, 1'b0);
    step(8'd200, 1'b1);
    check("t1_no_lock_first_cross", {meas_valid, locked}, 0);
    block(8'd200, 15, 1'b0);
    for (int r = 0; r < 3; r++) begin
      block(8'd50, 16, 1'b0);
      step(8'd200, 1'b1);
      check("t1_mv", meas_valid, 1);
      check("t1_period", period, 32);
      check("t1_pkmax", pk_max, 200);
      check("t1_pkmin", pk_min, 50);
      check("t1_amp", amp, 150);
      check("t1_locked", locked, 1);
      block(8'd200, 15, 1'b0);
    end
    check("t1_pulses", mv_n, 3);
    check("t1_locked_end", locked, 1);
    check("t1_no_timeout", to_n, 0);

    // Same wave with din_valid toggling every cycle
    do_reset("rst2");
    for (int r = 0; r < 4; r++) begin
      block(8'd50, 16, 1'b1);
      block(8'd200, 16, 1'b1);
    end
    check("t2_pulses", mv_n, 3);
    check("t2_period", period, 32);
    check("t2_amp", amp, 150);
    check("t2_gap", mv_gap, 64);

    // Timeout on CNT_W=8
    do_reset("rst3");
    lock8();
    block(8'd200, 254, 1'b0);
    check("t3_no_early_timeout", to8_n, 0);
    step(8'd200, 1'b1);
    check("t3_timeout", timeout8, 1);
    check("t3_unlocked", locked8, 0);
    check("t3_period_hold", period8, 32);
    check("t3_amp_hold", amp8, 150);
    check("t3_wide_no_timeout", to_n, 0);
    step(8'd200, 1'b1);
    check("t3_timeout_pulse", timeout8, 0);
    step(8'd50, 1'b1);
    step(8'd200, 1'b1);
    check("t3_no_mv_after_timeout", meas_valid8, 0);
    check("t3_timeouts", to8_n, 1);

    // Crossing coinciding with cnt=255 on CNT_W=8
    do_reset("rst6");
    lock8();
    block(8'd200, 253, 1'b0);
    step(8'd50, 1'b1);
    step(8'd200, 1'b1);
    check("t6_mv", meas_valid8, 1);
    check("t6_period", period8, 255);
    check("t6_amp", amp8, 150);
    check("t6_no_timeout", timeout8, 0);
    check("t6_timeouts", to8_n, 0);
    check("t6_locked", locked8, 1);

    // Reset mid-cycle after lock
    do_reset("rst4a");
    block(8'd50, 16, 1'b0);
    block(8'd200, 16, 1'b0);
    block(8'd50, 16, 1'b0);
    step(8'd200, 1'b1);
    check("t4_pre_mv", meas_valid, 1);
    block(8'd200, 8, 1'b0);
    do_reset("rst4b");
    block(8'd200, 8, 1'b0);
    block(8'd50, 16, 1'b0);
    block(8'd200, 16, 1'b0);
    block(8'd50, 16, 1'b0);
    check("t4_no_mv_one_cross", mv_n, 0);
    step(8'd200, 1'b1);
    check("t4_mv_second_cross", meas_valid, 1);
    check("t4_period", period, 32);

    // Midpoint chatter 127/129
    do_reset("rst5");
    for (int i = 0; i < 20; i++) begin
      step(8'd127, 1'b1);
      step(8'd129, 1'b1);
    end
`ifdef SINE_ANA_HYST_EN
    check("t5_pulses", mv_n, 0);
    check("t5_locked", locked, 0);
`else
    check("t5_pulses", mv_n, 19);
    check("t5_period", period, 2);
    check("t5_amp", amp, 2);
    check("t5_gap", mv_gap, 2);
    check("t5_locked", locked, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
